// File: rtl/ramarb.sv
// ramarb: round-robin arbiter placing N requesters onto one single-port RAM.
//
// Each requester presents a request (byte write mask, address, write data)
// with req_valid. One requester is granted per cycle, combinationally, and
// its fields are driven straight onto the RAM port with ram_ce. The RAM
// returns read data one cycle later. That data is steered back as a one-cycle
// rsp_valid strobe to the requester that was granted.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   req_valid[N]   request valid per requester
//   req_ready[N]   grant (one-hot or zero), combinational
//   req_we         per-requester byte write mask, slice k at [k*DW/8 +: DW/8]
//   req_addr       per-requester address, slice k at [k*AW +: AW]
//   req_din        per-requester write data, slice k at [k*DW +: DW]
//   rsp_valid[N]   response strobe, one cycle after acceptance
//   rsp_dout       response data (zero when no response)
//   ram_ce/we/addr/din   RAM command, all zero in idle cycles
//   ram_dout       RAM read data, valid the cycle after ram_ce
module ramarb #(
    parameter int N  = 2,
    parameter int DW = 16,
    parameter int AW = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          req_valid,
    output logic [N-1:0]          req_ready,
    input  logic [N*(DW/8)-1:0]   req_we,
    input  logic [N*AW-1:0]       req_addr,
    input  logic [N*DW-1:0]       req_din,
    output logic [N-1:0]          rsp_valid,
    output logic [DW-1:0]         rsp_dout,
    output logic                  ram_ce,
    output logic [DW/8-1:0]       ram_we,
    output logic [AW-1:0]         ram_addr,
    output logic [DW-1:0]         ram_din,
    input  logic [DW-1:0]         ram_dout
);

    localparam int BW = DW / 8;
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam logic [PW:0]   N_W  = (PW + 1)'(N);
    localparam logic [PW-1:0] LAST = PW'(N - 1);

    logic [PW-1:0] ptr_reg;
    logic [PW-1:0] ptr_next;
    logic [PW-1:0] rsp_idx_reg;
    logic          rsp_pend_reg;

    // Unpacked views of the flattened request buses.
    logic [BW-1:0] we_arr   [N];
    logic [AW-1:0] addr_arr [N];
    logic [DW-1:0] din_arr  [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_unpack
            assign we_arr[gi]   = req_we[gi*BW +: BW];
            assign addr_arr[gi] = req_addr[gi*AW +: AW];
            assign din_arr[gi]  = req_din[gi*DW +: DW];
        end
    endgenerate

    // Round-robin search: rotate req_valid so that bit 0 is the requester at
    // ptr, take the lowest set bit, then map the offset back to an index.
    logic [2*N-1:0] dbl_shift;
    logic [N-1:0]   rot;
    logic [PW-1:0]  off;
    logic [PW:0]    sum;
    logic           grant_any;
    logic [PW-1:0]  grant_idx;

    always_comb begin
        dbl_shift = {req_valid, req_valid} >> ptr_reg;
        rot       = dbl_shift[N-1:0];
        off       = '0;
        grant_any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!grant_any && rot[i]) begin
                grant_any = 1'b1;
                off       = PW'(i);
            end
        end
        // Nothing is granted while in reset.
        if (rst) begin
            grant_any = 1'b0;
        end
        sum = {1'b0, ptr_reg} + {1'b0, off};
        if (sum >= N_W) begin
            sum = sum - N_W;
        end
        grant_idx = sum[PW-1:0];
        ptr_next  = (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
    end

    always_comb begin
        req_ready = '0;
        ram_ce    = 1'b0;
        ram_we    = '0;
        ram_addr  = '0;
        ram_din   = '0;
        if (grant_any) begin
            req_ready[grant_idx] = 1'b1;
            ram_ce   = 1'b1;
            ram_we   = we_arr[grant_idx];
            ram_addr = addr_arr[grant_idx];
            ram_din  = din_arr[grant_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg      <= '0;
            rsp_idx_reg  <= '0;
            rsp_pend_reg <= 1'b0;
        end else begin
            rsp_pend_reg <= grant_any;
            if (grant_any) begin
                ptr_reg     <= ptr_next;
                rsp_idx_reg <= grant_idx;
            end
        end
    end

    // Masking with rst kills the response of a request accepted just before
    // reset asserts: it would otherwise appear in the first reset cycle.
    logic rsp_active;
    assign rsp_active = rsp_pend_reg && !rst;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rsp
            assign rsp_valid[gi] = rsp_active && (rsp_idx_reg == PW'(gi));
        end
    endgenerate

    assign rsp_dout = rsp_active ? ram_dout : '0;

endmodule

// File: tb/tb_ramarb.sv
// Directed testbench for ramarb (N=4, DW=16, AW=8) with a behavioural
// byte-writable RAM attached to the RAM port.
module tb_ramarb;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int AW = 8;
    localparam int BW = DW / 8;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [N-1:0]        req_valid = '0;
    logic [N-1:0]        req_ready;
    logic [N*BW-1:0]     req_we = '0;
    logic [N*AW-1:0]     req_addr = '0;
    logic [N*DW-1:0]     req_din = '0;
    logic [N-1:0]        rsp_valid;
    logic [DW-1:0]       rsp_dout;
    logic                ram_ce;
    logic [BW-1:0]       ram_we;
    logic [AW-1:0]       ram_addr;
    logic [DW-1:0]       ram_din;
    logic [DW-1:0]       ram_dout = '0;

    int total = 0;
    int bad   = 0;

    ramarb #(.N(N), .DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_din   (req_din),
        .rsp_valid (rsp_valid),
        .rsp_dout  (rsp_dout),
        .ram_ce    (ram_ce),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: read-before-write, byte-masked write.
    logic [DW-1:0] mem [256];
    always @(posedge clk) begin
        if (ram_ce) begin
            ram_dout <= mem[ram_addr];
            for (int b = 0; b < BW; b++) begin
                if (ram_we[b]) mem[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
            end
        end
    end

    task automatic set_req(input int k, input logic v, input logic [BW-1:0] we,
                           input logic [AW-1:0] addr, input logic [DW-1:0] din);
        req_valid[k]         = v;
        req_we[k*BW +: BW]   = we;
        req_addr[k*AW +: AW] = addr;
        req_din[k*DW +: DW]  = din;
    endtask

    task automatic clear_req();
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_din   = '0;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            rst = 1'b1;
            for (int k = 0; k < N; k++) set_req(k, 1'b1, 2'b11, AW'(k), 16'h1111);
            #1;
            total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready: got %b want %b", req_ready, 4'b0000); end
            total++; if (ram_ce !== 1'b0) begin bad++; $display("FAIL reset_ce: got %b want 0", ram_ce); end
            total++; if (ram_we !== 2'b00) begin bad++; $display("FAIL reset_we: got %b want 00", ram_we); end
            total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); end
            total++; if (rsp_dout !== 16'h0000) begin bad++; $display("FAIL reset_rsp_dout: got %h want 0000", rsp_dout); end
        end
    endtask

    task automatic test_contention();
        logic [3:0] exp_ready, exp_rsp;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rst = 1'b0;
            for (int k = 0; k < N; k++) set_req(k, 1'b1, 2'b00, AW'(8'h20 + k), 16'h0);
            #1;
            exp_ready = 4'b0001 << (i % 4);
            exp_rsp   = (i == 0) ? 4'b0000 : 4'b0001 << ((i - 1) % 4);
            total++; if (req_ready !== exp_ready) begin bad++; $display("FAIL contention_ready[%0d]: got %b want %b", i, req_ready, exp_ready); end
            total++; if (rsp_valid !== exp_rsp) begin bad++; $display("FAIL contention_rsp[%0d]: got %b want %b", i, rsp_valid, exp_rsp); end
            total++; if (ram_addr !== AW'(8'h20 + (i % 4))) begin bad++; $display("FAIL contention_addr[%0d]: got %h want %h", i, ram_addr, 8'h20 + (i % 4)); end
        end
    endtask

    task automatic test_wrap();
        logic [3:0] vpat [5] = '{4'b0010, 4'b1000, 4'b0011, 4'b0011, 4'b0011};
        logic [3:0] gexp [5] = '{4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b0001};
        logic [3:0] prev = 4'b1000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            clear_req();
            req_valid = vpat[i];
            #1;
            total++; if (req_ready !== gexp[i]) begin bad++; $display("FAIL wrap_ready[%0d]: got %b want %b", i, req_ready, gexp[i]); end
            total++; if (rsp_valid !== prev) begin bad++; $display("FAIL wrap_rsp[%0d]: got %b want %b", i, rsp_valid, prev); end
            prev = gexp[i];
        end
    endtask

    task automatic test_idle();
        @(negedge clk);
        clear_req();
        set_req(2, 1'b0, 2'b11, 8'h44, 16'hBEEF);
        #1;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL idle_ready: got %b want 0000", req_ready); end
        total++; if ({ram_ce, ram_we, ram_addr, ram_din} !== 27'd0) begin bad++; $display("FAIL idle_ram: got ce=%b we=%b addr=%h din=%h want all zero", ram_ce, ram_we, ram_addr, ram_din); end
        total++; if (rsp_valid !== 4'b0001) begin bad++; $display("FAIL idle_last_rsp: got %b want 0001", rsp_valid); end
        @(negedge clk);
        #1;
        total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL idle_rsp_valid: got %b want 0000", rsp_valid); end
        total++; if (rsp_dout !== 16'h0000) begin bad++; $display("FAIL idle_rsp_dout: got %h want 0000", rsp_dout); end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        clear_req();
        set_req(1, 1'b0, 2'b11, 8'h77, 16'hBEEF);
        set_req(0, 1'b1, 2'b11, 8'h05, 16'hA55A);
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL wr_ready: got %b want 0001", req_ready); end
        total++; if ({ram_ce, ram_we, ram_addr, ram_din} !== {1'b1, 2'b11, 8'h05, 16'hA55A}) begin bad++; $display("FAIL wr_ram: got ce=%b we=%b addr=%h din=%h want 1 11 05 a55a", ram_ce, ram_we, ram_addr, ram_din); end
        total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL wr_rsp_early: got %b want 0000", rsp_valid); end
        @(negedge clk);
        set_req(0, 1'b1, 2'b00, 8'h05, 16'h0000);
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rd_ready: got %b want 0001", req_ready); end
        total++; if (ram_we !== 2'b00) begin bad++; $display("FAIL rd_we: got %b want 00", ram_we); end
        total++; if (rsp_valid !== 4'b0001) begin bad++; $display("FAIL wr_rsp: got %b want 0001", rsp_valid); end
        @(negedge clk);
        clear_req();
        #1;
        total++; if (rsp_valid !== 4'b0001) begin bad++; $display("FAIL rd_rsp: got %b want 0001", rsp_valid); end
        total++; if (rsp_dout !== 16'hA55A) begin bad++; $display("FAIL rd_dout: got %h want a55a", rsp_dout); end
        total++; if (ram_ce !== 1'b0) begin bad++; $display("FAIL rd_idle_ce: got %b want 0", ram_ce); end
    endtask

    task automatic test_byte_mask();
        @(negedge clk);
        clear_req();
        set_req(2, 1'b1, 2'b11, 8'h10, 16'h1234);
        #1;
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL bm_ready: got %b want 0100", req_ready); end
        @(negedge clk);
        set_req(2, 1'b1, 2'b01, 8'h10, 16'hFFCD);
        #1;
        total++; if (ram_we !== 2'b01 || ram_din !== 16'hFFCD) begin bad++; $display("FAIL bm_ram: got we=%b din=%h want 01 ffcd", ram_we, ram_din); end
        total++; if (rsp_valid !== 4'b0100) begin bad++; $display("FAIL bm_rsp1: got %b want 0100", rsp_valid); end
        @(negedge clk);
        set_req(2, 1'b1, 2'b00, 8'h10, 16'h0000);
        #1;
        total++; if (rsp_dout !== 16'h1234) begin bad++; $display("FAIL bm_prewrite: got %h want 1234", rsp_dout); end
        @(negedge clk);
        clear_req();
        #1;
        total++; if (rsp_valid !== 4'b0100) begin bad++; $display("FAIL bm_rsp3: got %b want 0100", rsp_valid); end
        total++; if (rsp_dout !== 16'h12CD) begin bad++; $display("FAIL bm_dout: got %h want 12cd", rsp_dout); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  addrs [3] = '{8'h05, 8'h10, 8'h05};
        logic [15:0] datas [3] = '{16'hA55A, 16'h12CD, 16'hA55A};
        for (int i = 0; i <= 3; i++) begin
            @(negedge clk);
            clear_req();
            if (i < 3) set_req(1, 1'b1, 2'b00, addrs[i], 16'h0);
            #1;
            if (i < 3) begin
                total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL b2b_ready[%0d]: got %b want 0010", i, req_ready); end
            end
            if (i > 0) begin
                total++; if (rsp_valid !== 4'b0010) begin bad++; $display("FAIL b2b_rsp[%0d]: got %b want 0010", i, rsp_valid); end
                total++; if (rsp_dout !== datas[i-1]) begin bad++; $display("FAIL b2b_dout[%0d]: got %h want %h", i, rsp_dout, datas[i-1]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        clear_req();
        set_req(1, 1'b1, 2'b00, 8'h05, 16'h0);
        #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL rm_accept: got %b want 0010", req_ready); end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            rst = 1'b1;
            set_req(0, 1'b1, 2'b00, 8'h10, 16'h0);
            #1;
            total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL rm_rsp[%0d]: got %b want 0000", c, rsp_valid); end
            total++; if (req_ready !== 4'b0000 || ram_ce !== 1'b0) begin bad++; $display("FAIL rm_grant[%0d]: got ready=%b ce=%b want 0000 0", c, req_ready, ram_ce); end
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rm_first: got %b want 0001", req_ready); end
        @(negedge clk);
        #1;
        total++; if (rsp_valid !== 4'b0001 || req_ready !== 4'b0010) begin bad++; $display("FAIL rm_second: got rsp=%b ready=%b want 0001 0010", rsp_valid, req_ready); end
        // Leave ptr at 1, then reset: arbitration must restart from 0.
        @(negedge clk);
        clear_req();
        set_req(0, 1'b1, 2'b00, 8'h05, 16'h0);
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rm_pre: got %b want 0001", req_ready); end
        @(negedge clk);
        rst = 1'b1;
        set_req(1, 1'b1, 2'b00, 8'h10, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rm_ptr_clear: got %b want 0001", req_ready); end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_wrap();
        test_idle();
        test_write_read();
        test_byte_mask();
        test_back_to_back();
        test_reset_mid();
        @(negedge clk);
        clear_req();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ramarb.md
RAMARB -- requirements
Module: ramarb

Interface
REQ-001 Parameter N, default 2, number of requesters (2..8).
REQ-002 Parameter DW, default 16, data width; multiple of 8.
REQ-003 Parameter AW, default 8, address width.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  N  per-requester request valid.
REQ-007 req_ready  output  N  per-requester grant; one-hot or zero.
REQ-008 req_we  input  N*DW/8  per-requester byte write mask, requester k at [k*DW/8 +: DW/8]; all-zero means read.
REQ-009 req_addr  input  N*AW  per-requester address, requester k at [k*AW +: AW].
REQ-010 req_din  input  N*DW  per-requester write data, requester k at [k*DW +: DW].
REQ-011 rsp_valid  output  N  per-requester response strobe.
REQ-012 rsp_dout  output  DW  response data, shared by all requesters.
REQ-013 ram_ce  output  1  RAM chip enable.
REQ-014 ram_we  output  DW/8  RAM byte write mask.
REQ-015 ram_addr  output  AW  RAM address.
REQ-016 ram_din  output  DW  RAM write data.
REQ-017 ram_dout  input  DW  RAM read data, valid one cycle after ram_ce.

Function
REQ-018 Request handshake: requester k is accepted in a cycle when req_valid[k] and req_ready[k] are both 1.
REQ-019 Arbitration is round-robin with a priority pointer ptr (0..N-1).
- Grant goes to the first requester with req_valid=1, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
REQ-020 Grant is combinational from req_valid and ptr.
- req_ready has at most one bit set.
- req_ready is 0 when req_valid is 0 for that requester.
REQ-021 On each accepted grant to requester g, ptr updates to (g+1) mod N, wrapping from N-1 to 0.
- ptr holds when no grant occurs.
REQ-022 In a grant cycle, ram_ce=1 and ram_we/ram_addr/ram_din equal the granted requester's slices.
REQ-023 In a no-grant cycle: ram_ce=0, ram_we=0, ram_addr=0, ram_din=0.
REQ-024 Every accepted request (read or write) produces exactly one response.
- rsp_valid[g] = 1 for exactly one cycle, the cycle after acceptance.
- rsp_dout = ram_dout in that cycle. For a write, this is the pre-write RAM contents.
REQ-025 Response latency is fixed at 1 cycle.
- There is no response backpressure.
- Back-to-back grants produce back-to-back responses, tagged by a registered grant index.
REQ-026 rsp_valid has at most one bit set.
- When rsp_valid is all zero, rsp_dout = 0.
REQ-027 Requesters with req_valid held high must keep all request fields stable until accepted.
- The block shall not depend on this for correctness of other requesters.
REQ-028 A single requester continuously valid with no competition is granted every cycle (100% throughput).
REQ-029 With all N requesters continuously valid, each is granted exactly once in every N consecutive cycles.
- No requester waits more than N-1 cycles.

Reset
REQ-030 While rst=1:
- req_ready=0, ram_ce=0, ram_we=0.
- rsp_valid=0, rsp_dout=0.
- ptr=0 and the grant-index register clears.
REQ-031 A request accepted in the cycle before rst asserts shall produce no response.
- rsp_valid stays 0 in the first cycle of reset.
REQ-032 On the first cycle after rst deasserts, arbitration starts from ptr=0.

Verification
REQ-033 Single-requester write then read, N=2, DW=16:
- req 0 writes we=2'b11, addr=0x05, din=0xA55A, then reads addr=0x05.
- Expect req_ready[0]=1 both cycles and rsp_valid[0] on cycles 2 and 3.
- Second response rsp_dout=0xA55A.
REQ-034 Byte mask:
- addr=0x10 holds 0x1234; write we=2'b01, din=0xFFCD; then read.
- Expect rsp_dout=0x12CD.
REQ-035 Contention, N=4, all valid continuously from reset:
- Grant order 0,1,2,3,0,1,...
- rsp_valid follows the same order delayed by one cycle.
REQ-036 Pointer wrap, N=4, after a grant to 3:
- Only requesters 1 and 0 are valid.
- Expect grant to 0 first, then 1.
REQ-037 Reset mid-operation:
- Assert rst the cycle after req 1 is accepted.
- Expect rsp_valid=0 throughout reset.
- After release with req 0 and req 1 both valid, expect first grant to requester 0.
REQ-038 Idle cycles: req_valid=0 -> ram_ce=0, req_ready=0, rsp_valid=0 next cycle.
